// File: rtl/jt12_pg_acc_pkg.sv
// Shared widths, FSM encoding and pipeline tag payload for the phase accumulator.
package jt12_pg_acc_pkg;

  localparam int unsigned SLOTS_DEF = 24;
  localparam int unsigned PHW_DEF   = 20;
  localparam int unsigned INCW_DEF  = 17;
  localparam int unsigned OPW_DEF   = 10;
  localparam int unsigned DTW_DEF   = 6;
  localparam int unsigned MULW_DEF  = 4;
  localparam int unsigned SLOT_W    = 6;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pg_state_e;

  // Per-slot control that travels alongside the increment pipeline
  typedef struct packed {
    logic              valid;
    logic              pg_rst;
    logic [SLOT_W-1:0] slot;
  } pg_tag_t;

endpackage

// File: rtl/jt12_pg_inc.sv
// Two-stage increment path: detune add (wrapping), then x0.5 or integer multiply.
module jt12_pg_inc #(
  parameter int unsigned INCW = 17,
  parameter int unsigned PHW  = 20,
  parameter int unsigned DTW  = 6,
  parameter int unsigned MULW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic [INCW-1:0] phinc_pure,
  input  logic [DTW-1:0]  detune_signed,
  input  logic [MULW-1:0] mul,
  output logic [PHW-1:0]  inc
);

  localparam int unsigned PW = INCW + MULW;

  logic [INCW-1:0] premul;
  logic [MULW-1:0] mul_d1;
  logic [INCW-1:0] premul_c;
  logic [PW-1:0]   prod_c;
  logic [PHW-1:0]  inc_c;

  // Negative sums wrap modulo 2^INCW on purpose
  assign premul_c = phinc_pure + INCW'($signed(detune_signed));
  assign prod_c   = PW'(premul) * PW'(mul_d1);
  assign inc_c    = (mul_d1 == '0) ? PHW'(premul >> 1) : PHW'(prod_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      premul <= '0;
      mul_d1 <= '0;
      inc    <= '0;
    end else if (clk_en) begin
      premul <= premul_c;
      mul_d1 <= mul;
      inc    <= inc_c;
    end
  end

endmodule

// File: rtl/jt12_pg_acc.sv
// Time-multiplexed phase accumulator: slot sequencer, clear sweep, S3 add and phase register file.
module jt12_pg_acc
  import jt12_pg_acc_pkg::*;
#(
  parameter int unsigned SLOTS = SLOTS_DEF,
  parameter int unsigned PHW   = PHW_DEF,
  parameter int unsigned INCW  = INCW_DEF,
  parameter int unsigned OPW   = OPW_DEF,
  parameter int unsigned DTW   = DTW_DEF,
  parameter int unsigned MULW  = MULW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [INCW-1:0]   phinc_pure,
  input  logic [DTW-1:0]    detune_signed,
  input  logic [MULW-1:0]   mul,
  input  logic              pg_rst,
  input  logic              pg_stop,
  output logic [SLOT_W-1:0] in_slot,
  output logic              busy,
  output logic              op_valid,
  output logic [SLOT_W-1:0] op_slot,
  output logic [OPW-1:0]    phase_op
);

  localparam int unsigned       AW   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(SLOTS - 1);

  pg_state_e         state, state_nxt;
  logic [SLOT_W-1:0] clr_ptr, clr_ptr_nxt;
  logic [SLOT_W-1:0] in_slot_nxt;
  logic              busy_nxt;

  pg_tag_t           tag_d1, tag_d2;
  logic [PHW-1:0]    inc;

  logic [PHW-1:0]    phase_mem [SLOTS];
  logic [PHW-1:0]    phase_rd_c;
  logic [PHW-1:0]    phase_nxt_c;
  logic              mem_we_c;
  logic [SLOT_W-1:0] mem_addr_c;
  logic [PHW-1:0]    mem_wdata_c;

  jt12_pg_inc #(
    .INCW (INCW),
    .PHW  (PHW),
    .DTW  (DTW),
    .MULW (MULW)
  ) u_inc (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .phinc_pure    (phinc_pure),
    .detune_signed (detune_signed),
    .mul           (mul),
    .inc           (inc)
  );

  // S3: pg_rst beats pg_stop; pg_stop is taken live, not from the slot's input tick
  assign phase_rd_c  = phase_mem[AW'(tag_d2.slot)];
  assign phase_nxt_c = tag_d2.pg_rst ? '0 :
                       pg_stop       ? phase_rd_c :
                                       phase_rd_c + inc;

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    in_slot_nxt = in_slot;
    busy_nxt    = busy;
    mem_we_c    = 1'b0;
    mem_addr_c  = clr_ptr;
    mem_wdata_c = '0;
    case (state)
      ST_INIT: begin
        mem_we_c    = 1'b1;
        clr_ptr_nxt = clr_ptr + SLOT_W'(1);
        if (clr_ptr == LAST) begin
          clr_ptr_nxt = '0;
          state_nxt   = ST_RUN;
          busy_nxt    = 1'b0;
          in_slot_nxt = '0;
        end
      end
      ST_RUN: begin
        in_slot_nxt = (in_slot == LAST) ? '0 : in_slot + SLOT_W'(1);
        mem_we_c    = tag_d2.valid;
        mem_addr_c  = tag_d2.slot;
        mem_wdata_c = phase_nxt_c;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_INIT;
      clr_ptr <= '0;
      in_slot <= '0;
      busy    <= 1'b1;
    end else if (clk_en) begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
      in_slot <= in_slot_nxt;
      busy    <= busy_nxt;
    end
  end

  // Tags only go valid for slots sampled in RUN, so the sweep never leaks into S3
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_d1   <= '0;
      tag_d2   <= '0;
      op_valid <= 1'b0;
      op_slot  <= '0;
      phase_op <= '0;
    end else if (clk_en) begin
      tag_d1   <= '{valid: (state == ST_RUN), pg_rst: pg_rst, slot: in_slot};
      tag_d2   <= tag_d1;
      op_valid <= tag_d2.valid;
      if (tag_d2.valid) begin
        op_slot  <= tag_d2.slot;
        phase_op <= phase_nxt_c[PHW-1 -: OPW];
      end
    end
  end

  // Register file without reset; contents are defined by the clear sweep
  always_ff @(posedge clk) begin
    if (clk_en && mem_we_c) begin
      phase_mem[AW'(mem_addr_c)] <= mem_wdata_c;
    end
  end

endmodule
